// File: rtl/posit_dec_arbiter.sv
// posit_dec_arbiter: round-robin share of one posit decoder with a registered valid/ready result
module posit_dec_arbiter #(
  parameter int N    = 32,
  parameter int ES   = 3,
  parameter int RS   = 6,
  parameter int FS   = N - ES - 3,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0] req_ready,
  output logic [N-1:0]    dec_in,
  input  logic            dec_sign,
  input  logic [RS-1:0]   dec_r,
  input  logic [ES-1:0]   dec_e,
  input  logic [FS-1:0]   dec_frac,
  input  logic            dec_z,
  input  logic            dec_inf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDW-1:0]  out_id,
  output logic            out_sign,
  output logic [RS-1:0]   out_r,
  output logic [ES-1:0]   out_e,
  output logic [FS-1:0]   out_frac,
  output logic            out_z,
  output logic            out_inf,
  output logic [15:0]     done_cnt,
  input  logic            done_clr
);
  logic [IDW-1:0] rr_ptr, gnt_id;
  logic can_issue, gnt;
  function automatic logic [IDW-1:0] wrap(input int j);
    return IDW'(j >= NREQ ? j - NREQ : j);
  endfunction
  assign can_issue = (~out_valid | out_ready) & ~rst;
  // scan from the farthest offset down so the requester nearest rr_ptr wins
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (can_issue && req_valid[wrap(int'(rr_ptr) + k)]) begin
        gnt = 1'b1;
        gnt_id = wrap(int'(rr_ptr) + k);
      end
    end
  end
  assign req_ready = gnt ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  assign dec_in = gnt ? req_data[int'(gnt_id)*N +: N] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rr_ptr <= '0;
      done_cnt <= '0;
      out_id <= '0;
      out_sign <= 1'b0;
      out_r <= '0;
      out_e <= '0;
      out_frac <= '0;
      out_z <= 1'b0;
      out_inf <= 1'b0;
    end else begin
      if (gnt) begin
        out_valid <= 1'b1;
        rr_ptr <= wrap(int'(gnt_id) + 1);
        out_id <= gnt_id;
        out_sign <= dec_sign;
        out_r <= dec_r;
        out_e <= dec_e;
        out_frac <= dec_frac;
        out_z <= dec_z;
        out_inf <= dec_inf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      done_cnt <= done_clr ? '0 : (out_valid & out_ready & ~&done_cnt) ? done_cnt + 16'd1 : done_cnt;
    end
  end
endmodule

// File: tb/tb_posit_dec_arbiter.sv
// tb_posit_dec_arbiter: directed checks of arbitration, flow control, reset and counter saturation
module tb_posit_dec_arbiter;
  localparam int N = 32, ES = 3, RS = 6, FS = 26, NREQ = 4, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*N-1:0] req_data = '0;
  logic [N-1:0] dec_in;
  logic dec_sign, dec_z, dec_inf;
  logic [RS-1:0] dec_r;
  logic [ES-1:0] dec_e;
  logic [FS-1:0] dec_frac;
  logic out_valid, out_ready = 1'b0, out_sign, out_z, out_inf, done_clr = 1'b0;
  logic [IDW-1:0] out_id;
  logic [RS-1:0] out_r;
  logic [ES-1:0] out_e;
  logic [FS-1:0] out_frac;
  logic [15:0] done_cnt;
  int checks = 0, errors = 0;

  posit_dec_arbiter #(.N(N), .ES(ES), .RS(RS), .FS(FS), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dec_in(dec_in), .dec_sign(dec_sign), .dec_r(dec_r), .dec_e(dec_e), .dec_frac(dec_frac),
    .dec_z(dec_z), .dec_inf(dec_inf), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_sign(out_sign), .out_r(out_r), .out_e(out_e), .out_frac(out_frac),
    .out_z(out_z), .out_inf(out_inf), .done_cnt(done_cnt), .done_clr(done_clr)
  );

  always #5 clk = ~clk;

  // stand-in decoder: bit slices plus zero/NaR flags
  function automatic logic [37:0] stub(input logic [31:0] w);
    return {w[31], w[30:25], w[24:22], w[25:0], w == 32'h0, w == 32'h8000_0000};
  endfunction
  always_comb {dec_sign, dec_r, dec_e, dec_frac, dec_z, dec_inf} = stub(dec_in);

  wire [37:0] out_word = {out_sign, out_r, out_e, out_frac, out_z, out_inf};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [31:0] w);
    req_data[k*N +: N] = w;
  endtask

  initial begin
    req_valid = 4'hF;
    out_ready = 1'b1;
    #12;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_cnt", 64'(done_cnt), 64'h0);
    req_valid = '0;
    rst = 1'b0;
    step();
    // single requester
    put(2, 32'h4000_0000);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(req_ready), 64'h4);
    check("single_dec_in", 64'(dec_in), 64'h4000_0000);
    step();
    req_valid = '0;
    #1;
    check("single_valid", 64'(out_valid), 64'h1);
    check("single_id", 64'(out_id), 64'h2);
    check("single_word", 64'(out_word), 64'(stub(32'h4000_0000)));
    check("single_cnt0", 64'(done_cnt), 64'h0);
    step();
    check("single_cnt1", 64'(done_cnt), 64'h1);
    check("single_drain", 64'(out_valid), 64'h0);
    // round robin after reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) put(k, 32'h1000_0000 * (k + 1));
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_grant", 64'(req_ready), 64'(1 << (i % 4)));
      if (i > 0) check("rr_id", 64'(out_id), 64'((i - 1) % 4));
      step();
    end
    req_valid = '0;
    #1;
    check("rr_last_id", 64'(out_id), 64'h3);
    check("rr_cnt7", 64'(done_cnt), 64'd7);
    step();
    check("rr_cnt8", 64'(done_cnt), 64'd8);
    // backpressure
    put(0, 32'hAAAA_0000);
    req_valid = 4'b0001;
    step();
    out_ready = 1'b0;
    put(1, 32'h1234_5678);
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'h0);
      check("bp_hold", {25'h0, out_valid, out_id, out_word}, {25'h0, 1'b1, 2'd0, stub(32'hAAAA_0000)});
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_nobubble", 64'(req_ready), 64'h2);
    step();
    check("bp_next", {25'h0, out_valid, out_id, out_word}, {25'h0, 1'b1, 2'd1, stub(32'h1234_5678)});
    check("bp_cnt", 64'(done_cnt), 64'd9);
    // zero and NaR pass through
    put(1, 32'h0);
    step();
    check("zero_flags", {out_z, out_inf}, 64'b10);
    put(1, 32'h8000_0000);
    step();
    check("nar_flags", {out_sign, out_z, out_inf}, 64'b101);
    // reset while stalled
    put(0, 32'hFFFF_FFFF);
    req_valid = 4'b0001;
    step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_out", {25'h0, out_valid, out_id, out_word}, 64'h0);
    check("mid_rst_cnt", 64'(done_cnt), 64'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    check("mid_rst_first", 64'(req_ready), 64'h1);
    // saturating counter
    req_valid = 4'b0001;
    for (int i = 0; i < 65536; i++) step();
    check("sat_reach", 64'(done_cnt), 64'hFFFF);
    for (int i = 0; i < 3; i++) step();
    check("sat_hold", 64'(done_cnt), 64'hFFFF);
    done_clr = 1'b1;
    step();
    check("clr_prio", 64'(done_cnt), 64'h0);
    done_clr = 1'b0;
    step();
    check("clr_resume", 64'(done_cnt), 64'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
